// File: rtl/gpu_pkg.sv
// Shared definitions for the draw-list fetcher and the GPU draw-call queue.
//   - list_state_e : list sequencer states
//   - DESC_WORDS   : words loaded per descriptor (higher words are ignored)
//   - Ofs*         : word offsets inside a descriptor
//   - drawcall_t   : one draw call as pushed into the GPU queue
//   - put_word     : write one 16-bit descriptor word into a drawcall_t
package gpu_pkg;

  localparam int unsigned DESC_WORDS = 9;

  localparam logic [3:0] OfsAddrLo   = 4'd0;
  localparam logic [3:0] OfsAddrHi   = 4'd1;
  localparam logic [3:0] OfsAddrX    = 4'd2;
  localparam logic [3:0] OfsAddrY    = 4'd3;
  localparam logic [3:0] OfsSheet    = 4'd4;
  localparam logic [3:0] OfsWidth    = 4'd5;
  localparam logic [3:0] OfsHeight   = 4'd6;
  localparam logic [3:0] OfsX        = 4'd7;
  localparam logic [3:0] OfsY        = 4'd8;

  typedef struct packed {
    logic [31:0] address;
    logic [15:0] address_x;
    logic [15:0] address_y;
    logic [15:0] sheetsize;
    logic [15:0] width;
    logic [15:0] height;
    logic [15:0] x;
    logic [15:0] y;
  } drawcall_t;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StIssue,
    StDone
  } list_state_e;

  // Offsets outside the descriptor leave the draw call unchanged.
  function automatic drawcall_t put_word(drawcall_t d, logic [3:0] ofs, logic [15:0] w);
    drawcall_t r;
    r = d;
    case (ofs)
      OfsAddrLo: r.address[15:0]  = w;
      OfsAddrHi: r.address[31:16] = w;
      OfsAddrX:  r.address_x      = w;
      OfsAddrY:  r.address_y      = w;
      OfsSheet:  r.sheetsize      = w;
      OfsWidth:  r.width          = w;
      OfsHeight: r.height         = w;
      OfsX:      r.x              = w;
      OfsY:      r.y              = w;
      default:   r                = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/desc_loader.sv
// Descriptor read pipeline: issues reads for words 0..DESC_WORDS-1 of one
// descriptor and assembles them into a shadow drawcall_t.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   load, load_addr   : start a new descriptor at load_addr
//   fetch             : read requests are allowed
//   mem_req/addr/gnt  : read request handshake (accept on req && gnt)
//   mem_rdata         : read data, valid the cycle after the accept
//   desc              : shadow fields including the word arriving this cycle
//   desc_last         : the final descriptor word arrives this cycle
module desc_loader
  import gpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_addr,
  input  logic        fetch,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [15:0] mem_rdata,
  output drawcall_t   desc,
  output logic        desc_last
);

  logic [15:0] addr_q;
  logic [3:0]  issued_q;
  logic        cap_valid_q;
  logic [3:0]  cap_ofs_q;
  drawcall_t   shadow_q;
  logic        accept;

  assign mem_req   = fetch && (issued_q < 4'(DESC_WORDS));
  assign mem_addr  = addr_q;
  assign accept    = mem_req && mem_gnt;

  // Merge the in-flight word so the top can take the complete descriptor on
  // the same edge the last word is captured.
  assign desc      = cap_valid_q ? put_word(shadow_q, cap_ofs_q, mem_rdata) : shadow_q;
  assign desc_last = cap_valid_q && (cap_ofs_q == OfsY);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      issued_q    <= 4'(DESC_WORDS);
      cap_valid_q <= 1'b0;
      cap_ofs_q   <= '0;
      shadow_q    <= '0;
    end else begin
      shadow_q    <= desc;
      cap_valid_q <= accept;
      if (accept) cap_ofs_q <= issued_q;
      if (load) begin
        addr_q   <= load_addr;
        issued_q <= '0;
      end else if (accept) begin
        addr_q   <= addr_q + 16'd1;
        issued_q <= issued_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/draw_list_fetcher.sv
// Walks a list of draw descriptors in 16-bit memory and pushes one draw call
// per descriptor into the GPU queue, stalling while the queue is full.
// Optional feature macro: DRAW_LIST_SKIP_EMPTY_EN -- descriptors with zero
// width or height are dropped without a draw and without touching ctrl_*.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start, list_addr,
//   list_count            : run a list (sampled only when idle)
//   busy, done            : list in progress / one-cycle completion pulse
//   mem_*                 : descriptor read port
//   ctrl_*                : registered draw-call fields, ctrl_draw push,
//                           ctrl_full back-pressure
// DESC_STRIDE must be a power of two and at least 9.
module draw_list_fetcher
  import gpu_pkg::*;
#(
  parameter int unsigned DESC_STRIDE = 16,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [15:0]            list_addr,
  input  logic [COUNT_WIDTH-1:0] list_count,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            mem_addr,
  output logic                   mem_req,
  input  logic                   mem_gnt,
  input  logic [15:0]            mem_rdata,
  output logic [31:0]            ctrl_address,
  output logic [15:0]            ctrl_address_x,
  output logic [15:0]            ctrl_address_y,
  output logic [15:0]            ctrl_sheetsize,
  output logic [15:0]            ctrl_width,
  output logic [15:0]            ctrl_height,
  output logic [15:0]            ctrl_x,
  output logic [15:0]            ctrl_y,
  output logic                   ctrl_draw,
  input  logic                   ctrl_full
);

  list_state_e            state_q, state_d;
  logic [15:0]            base_q, base_d, next_base;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] idx_q, idx_d, idx_inc;
  drawcall_t              ctrl_q, ctrl_d;
  drawcall_t              desc;
  logic                   desc_last;
  logic                   load;
  logic [15:0]            load_addr;
  logic                   advance;
  logic                   skip;

  assign next_base = base_q + 16'(DESC_STRIDE);
  assign idx_inc   = idx_q + COUNT_WIDTH'(1);

`ifdef DRAW_LIST_SKIP_EMPTY_EN
  assign skip = (desc.width == '0) || (desc.height == '0);
`else
  assign skip = 1'b0;
`endif

  desc_loader u_desc_loader (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_addr (load_addr),
    .fetch     (state_q == StFetch),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_rdata (mem_rdata),
    .desc      (desc),
    .desc_last (desc_last)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    idx_d     = idx_q;
    ctrl_d    = ctrl_q;
    busy      = 1'b0;
    done      = 1'b0;
    ctrl_draw = 1'b0;
    load      = 1'b0;
    load_addr = next_base;
    advance   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d  = list_addr;
          count_d = list_count;
          idx_d   = '0;
          if (list_count == '0) begin
            state_d = StDone;
          end else begin
            state_d   = StFetch;
            load      = 1'b1;
            load_addr = list_addr;
          end
        end
      end
      StFetch: begin
        busy = 1'b1;
        if (desc_last) begin
          if (skip) begin
            advance = 1'b1;
          end else begin
            // Outputs only change here, so a pending draw is never disturbed.
            ctrl_d  = desc;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        busy = 1'b1;
        if (!ctrl_full) begin
          ctrl_draw = 1'b1;
          advance   = 1'b1;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      idx_d  = idx_inc;
      base_d = next_base;
      if (idx_inc == count_q) begin
        state_d = StDone;
      end else begin
        state_d = StFetch;
        load    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      base_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign ctrl_address   = ctrl_q.address;
  assign ctrl_address_x = ctrl_q.address_x;
  assign ctrl_address_y = ctrl_q.address_y;
  assign ctrl_sheetsize = ctrl_q.sheetsize;
  assign ctrl_width     = ctrl_q.width;
  assign ctrl_height    = ctrl_q.height;
  assign ctrl_x         = ctrl_q.x;
  assign ctrl_y         = ctrl_q.y;

endmodule
